scan_master: RTL
================

Name: scan_master

Overview:
- Sequencer that drives the on-chip scan interface (scan_clk, scan_en, scan_in) from a parallel write request.
- A request carries a 12-bit chain address and a 160-bit payload. The block serialises them as one framed scan transaction: address MSB-first, then data MSB-first.
- It then performs the scan_en fall that latches the addressed chain, and one idle scan_clk pulse that returns the chain's subclk FSM to idle.
- Sits between the host register bank (MMIO or debug bridge) and the ScanTop pins.

Parameters:
- ADDR_W, 12, chain address bits shifted per frame.
- DATA_W, 160, payload bits shifted per frame.
- CLK_DIV, 4, scan_clk half-period in clk cycles; must be ≥1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept
- req_addr  in  ADDR_W  target chain address
- req_data  in  DATA_W  payload; bit DATA_W-1 is shifted first
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- rd_data  out  DATA_W  captured scan_out bits (only with the optional feature)
- scan_clk  out  1  generated scan clock
- scan_en  out  1  scan enable
- scan_in  out  1  serial data
- scan_out  in  1  serial return from the chain

Behaviour:
- Reset (async, reset_n=0): scan_clk=0, scan_en=0, scan_in=0, busy=0, done=0, rd_data=0, state=IDLE, all counters 0. Reset mid-frame aborts immediately with no done pulse. The chain may latch partial data on the scan_en fall; software must rewrite that chain.
- Reset values of all outputs apply regardless of state.
- Request handshake:
  - req_ready = (state==IDLE).
  - Acceptance happens on the edge where req_valid && req_ready; call it T0. H denotes CLK_DIV.
  - req_addr and req_data are copied into shift registers at T0. Later changes on the inputs have no effect.
  - req_valid while busy is ignored; no queueing.
- All scan outputs are registered. scan_in and scan_en change only on edges where scan_clk falls (or at T0). This gives H cycles of setup to the rising edge.
- FSM states and transitions:
  - IDLE → ADDR on acceptance. scan_en=1, scan_in=addr[ADDR_W-1].
  - ADDR: ADDR_W bit periods. Each bit period is H cycles low followed by H cycles high. On each falling edge, present the next bit. After the last address bit → DATA.
  - DATA: DATA_W bit periods, same timing. The final rise (bit 171 overall) occurs at T0+343H.
  - LATCH: at T0+344H, scan_clk falls and scan_en=0, scan_in=0 on the same edge. Hold for H cycles.
  - FLUSH: one scan_clk pulse with scan_en=0. Rise at T0+345H, fall at T0+346H, then hold low H cycles.
  - DONE: at edge T0+347H, done=1 for one cycle and state → IDLE. busy falls on the same edge.
- Frame length: (2·(ADDR_W+DATA_W)+3)·H clk cycles, i.e. 1388 at defaults.
- Counters:
  - Half-period counter counts 0..H-1.
  - Bit counter is wide enough for ADDR_W+DATA_W; no wrap within a frame.
  - Both clear on every state entry.
- CLK_DIV=1 gives scan_clk=clk/2 and is legal.

Optional Feature:
- Macro: SCAN_MASTER_READBACK_EN.
- Enabled: in DATA, scan_out is sampled on the clk edge where scan_clk rises. It is shifted into rd_data, giving DATA_W samples, first sample ends at the MSB. rd_data updates only at DONE and holds until the next DONE.
- Disabled: rd_data is tied to 0 and scan_out is unused.

Decomposition:
- Package scan_pkg holds:
  - ADDR_W and DATA_W
  - chain address constants: OSC=1, RF_ANLG=2, SUPPLY=3, RADAR=4, SENSOR_ADC=5
  - state enum {IDLE, ADDR, DATA, LATCH, FLUSH, DONE}
- One sub-module, scan_clk_gen: half-period tick counter plus scan_clk toggle. It exports rise_tick and fall_tick strobes and has a synchronous enable/clear.

Test Plan:
- Reset: hold reset_n=0 → scan_clk=0, scan_en=0, scan_in=0, busy=0, done=0, req_ready=1. Assert reset_n=0 asynchronously mid-cycle → outputs clear without waiting for a clk edge.
- Single write, CLK_DIV=4, req_addr=12'h004, req_data=160'hA5…A5 against a ScanTop model:
  - model sees 12'h004 then the payload on scan_clk rises with scan_en=1
  - scan_en falls at T0+1376 with scan_clk low
  - RADAR outputs update to the payload
  - one flush pulse occurs
  - done pulses at T0+1388
- Back-to-back: hold req_valid with addr 12'h002, then 12'h003 → second accepted one cycle after first done. No scan_clk glitch; both chains are updated.
- Busy protection: toggle req_valid and change req_data during DATA → not accepted, shifted bits unchanged, exactly one done.
- Reset mid-DATA (bit 60) → outputs zero immediately, no done. A subsequent full write to 12'h001 completes correctly.
- SCAN_MASTER_READBACK_EN with a loopback model (scan_out = scan_in registered on scan_clk rise) → rd_data equals req_data shifted by one bit, valid at done.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared constants and types for the scan master: default frame geometry,
// known chain addresses and the sequencer state encoding.
package scan_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 160;

  localparam logic [ADDR_W-1:0] CHAIN_OSC        = 12'd1;
  localparam logic [ADDR_W-1:0] CHAIN_RF_ANLG    = 12'd2;
  localparam logic [ADDR_W-1:0] CHAIN_SUPPLY     = 12'd3;
  localparam logic [ADDR_W-1:0] CHAIN_RADAR      = 12'd4;
  localparam logic [ADDR_W-1:0] CHAIN_SENSOR_ADC = 12'd5;

  // DONE is the completion point; the sequencer passes through it on the
  // same edge it returns to IDLE, so it is never held as a registered state.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    LATCH = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/scan_clk_gen.sv
// Half-period timer and scan_clk toggle flop. rise_tick/fall_tick flag the
// clk edge on which scan_clk is about to rise/fall. en runs the timer; clr
// forces the counter and scan_clk low and wins over a pending toggle.
module scan_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic scan_clk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             tick;

  assign tick      = en && (cnt_q == CNT_MAX);
  assign rise_tick = tick && !sclk_q;
  assign fall_tick = tick && sclk_q;
  assign scan_clk  = sclk_q;

  // Next counter / scan_clk value: clear, toggle on terminal count, or count.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Timer and scan_clk registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/scan_master.sv
// Scan master: serialises {address, payload} MSB-first onto scan_in with
// scan_en high, drops scan_en to latch the chain, then gives one idle
// scan_clk pulse before reporting done.
// Optional readback (define SCAN_MASTER_READBACK_EN): scan_out is sampled on
// each scan_clk rise during DATA and presented on rd_data at done.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   ADDR  | shifting the chain address
//   DATA  | shifting the payload
//   LATCH | scan_en low, scan_clk low for one half period
//   FLUSH | single scan_clk pulse with scan_en low, then low half period
//   DONE  | completion point, merged with the return to IDLE
module scan_master #(
  parameter int ADDR_W  = scan_pkg::ADDR_W,
  parameter int DATA_W  = scan_pkg::DATA_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              scan_clk,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              scan_out
);
  import scan_pkg::*;

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  state_e             state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic               scan_en_q, scan_en_d;
  logic               scan_in_q, scan_in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               gen_en, gen_clr, rise_tick, fall_tick;

  // The timer only runs while a frame is active and is parked low whenever
  // the next state is IDLE, which suppresses the rise after the flush pulse.
  assign gen_en  = (state_q != IDLE);
  assign gen_clr = (state_d == IDLE);

  scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (gen_en),
    .clr       (gen_clr),
    .scan_clk  (scan_clk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign req_ready = (state_q == IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign scan_en   = scan_en_q;
  assign scan_in   = scan_in_q;

  // Next-state and scan output logic; new bits are presented on scan_clk falls.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    scan_en_d = scan_en_q;
    scan_in_d = scan_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = ADDR;
          bit_cnt_d = '0;
          sreg_d    = {req_addr, req_data};
          scan_en_d = 1'b1;
          scan_in_d = req_addr[ADDR_W-1];
          busy_d    = 1'b1;
        end
      end
      ADDR: begin
        if (fall_tick) begin
          sreg_d    = sreg_q << 1;
          scan_in_d = sreg_q[FRAME_W-2];
          if (bit_cnt_q == BIT_W'(ADDR_W - 1)) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      DATA: begin
        if (fall_tick) begin
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            state_d   = LATCH;
            bit_cnt_d = '0;
            scan_en_d = 1'b0;
            scan_in_d = 1'b0;
          end else begin
            sreg_d    = sreg_q << 1;
            scan_in_d = sreg_q[FRAME_W-2];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      LATCH: begin
        if (rise_tick) begin
          state_d   = FLUSH;
          bit_cnt_d = '0;
        end
      end
      FLUSH: begin
        // The flush pulse's own fall is ignored; the next timer expiry ends the frame.
        if (rise_tick) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer and scan output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      scan_en_q <= 1'b0;
      scan_in_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      scan_en_q <= scan_en_d;
      scan_in_q <= scan_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef SCAN_MASTER_READBACK_EN
  logic [DATA_W-1:0] rd_sh_q, rd_sh_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  assign rd_data = rd_data_q;

  // Capture scan_out on DATA rises; publish the full word only at completion.
  always_comb begin
    rd_sh_d   = rd_sh_q;
    rd_data_d = rd_data_q;
    if (state_q == IDLE && req_valid) begin
      rd_sh_d = '0;
    end else if (state_q == DATA && rise_tick) begin
      rd_sh_d = {rd_sh_q[DATA_W-2:0], scan_out};
    end
    if (done_d) begin
      rd_data_d = rd_sh_q;
    end
  end

  // Readback shift and holding registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sh_q   <= '0;
      rd_data_q <= '0;
    end else begin
      rd_sh_q   <= rd_sh_d;
      rd_data_q <= rd_data_d;
    end
  end
`else
  logic unused_scan_out;

  assign unused_scan_out = scan_out;
  assign rd_data         = '0;
`endif

endmodule
